npu_add_tree_top: RTL and testbench
===================================

NPU_ADD_TREE_TOP -- requirements
Module: npu_add_tree_top

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset, synchronous and active-high.
REQ-004 add_tree_data  input  64  eight 8-bit data lanes; lane i = bits [8i+7:8i], i=0..7.
REQ-005 add_tree_para  input  64  eight 8-bit parameter lanes, same lane mapping, always two's-complement signed.
REQ-006 is_signed_data  input  1  1 = data lanes signed two's complement; 0 = data lanes unsigned (0..255).
REQ-007 add_result  output  19  registered two's-complement dot product of the data and parameter lanes.

Function
REQ-008 Per lane, the block SHALL form P_i = D_i x W_i, where W_i is signed 8-bit and D_i is sign-extended when is_signed_data=1 and zero-extended when is_signed_data=0, each as a signed 9-bit operand; P_i is 17-bit signed.
REQ-009 The block SHALL sum P_0..P_7 through a 3-level balanced adder tree: 4 adders, then 2, then 1.
- Each level SHALL sign-extend by one bit: 18-bit, 19-bit, 20-bit.
REQ-010 add_result SHALL equal the low 19 bits of the exact sum.
- The range is -261120..259080 unsigned and -130048..131072 signed, so overflow SHALL never occur.
REQ-011 Latency (default build) SHALL be exactly 1 clock: operands present before rising edge N appear on add_result immediately after edge N.
- Multiply and tree are combinational.
- The output register is the only state.
REQ-012 The block SHALL accept new operands every clock, with no handshake, valid or stall.
REQ-013 is_signed_data SHALL be sampled in the same cycle as its operands; changing it between cycles SHALL affect only that cycle's result.
REQ-014 Lane order SHALL NOT affect the result, because the sum is commutative.

Reset
REQ-015 When rst=1 at a rising edge, add_result and all pipeline registers SHALL become 0.
- Reset takes priority over loading new data.
REQ-016 The first valid result after rst deasserts SHALL come from operands present at the first edge with rst=0.
- Reset mid-stream discards all in-flight results.

Configuration
REQ-017 Macro NPU_ADD_TREE_PIPE_EN, when defined, SHALL add a register stage holding the eight 17-bit products between the multipliers and the adder tree.
- Latency becomes 2 clocks.
- Throughput stays 1 per clock.
- rst clears this stage to 0.
REQ-018 Without NPU_ADD_TREE_PIPE_EN, the block SHALL behave per REQ-011 with 1-clock latency.
- Results SHALL be bit-identical in both builds apart from latency.

Verification
REQ-019 All lanes data=0xFF, para=0x80, is_signed_data=0 -> add_result = -261120 (0x40400) after 1 clock.
REQ-020 All lanes data=0xFF, para=0x7F, is_signed_data=0 -> 259080.
- Same operands with is_signed_data=1 -> -1016.
REQ-021 All lanes data=0x80, para=0x80, is_signed_data=1 -> 131072 (0x20000).
- Same operands with is_signed_data=0 -> -131072.
REQ-022 Hold rst=1 with nonzero operands -> add_result=0 every cycle.
- Deassert rst -> the correct result appears 1 clock later (2 clocks with NPU_ADD_TREE_PIPE_EN).
REQ-023 10000 random 64-bit data/para pairs, new pair every clock, on two instances (is_signed_data tied 1 and 0).
- Each result SHALL match the reference sum of REQ-008 at the specified latency, with zero mismatches.
REQ-024 Single nonzero lane: lane 5 data=0x03, para=0xFE, others 0, is_signed_data=1 -> -6, checking lane mapping.

Source files
------------

// File: rtl/npu_add_tree_top.sv
// npu_add_tree_top: 8-lane int8 dot product through a 3-level adder tree with a registered 19-bit result.
// Defining NPU_ADD_TREE_PIPE_EN adds a product register stage, making the latency 2 clocks.
module npu_add_tree_top (
  input  logic        clk,
  input  logic        rst,
  input  logic [63:0] add_tree_data,
  input  logic [63:0] add_tree_para,
  input  logic        is_signed_data,
  output logic [18:0] add_result
);
  logic [7:0][16:0] prod_d;
  logic [7:0][16:0] prod;
  logic [3:0][17:0] sum1;
  logic [1:0][18:0] sum2;
  logic [18:0]      add_result_d;
  logic [18:0]      add_result_q;
  for (genvar i = 0; i < 8; i++) begin : g_mul
    logic signed [16:0] d_x;
    logic signed [16:0] w_x;
    assign d_x = {{9{is_signed_data & add_tree_data[8*i+7]}}, add_tree_data[8*i +: 8]};
    assign w_x = {{9{add_tree_para[8*i+7]}}, add_tree_para[8*i +: 8]};
    assign prod_d[i] = d_x * w_x;
  end
`ifdef NPU_ADD_TREE_PIPE_EN
  logic [7:0][16:0] prod_q;
  always_ff @(posedge clk) prod_q <= rst ? '0 : prod_d;
  assign prod = prod_q;
`else
  assign prod = prod_d;
`endif
  // The final add keeps only 19 bits: the full sum never leaves that range.
  always_comb begin
    for (int j = 0; j < 4; j++)
      sum1[j] = {prod[2*j][16], prod[2*j]} + {prod[2*j+1][16], prod[2*j+1]};
    for (int j = 0; j < 2; j++)
      sum2[j] = {sum1[2*j][17], sum1[2*j]} + {sum1[2*j+1][17], sum1[2*j+1]};
    add_result_d = sum2[0] + sum2[1];
  end
  always_ff @(posedge clk) add_result_q <= rst ? '0 : add_result_d;
  assign add_result = add_result_q;
endmodule

// File: tb/tb_npu_add_tree_top.sv
// tb_npu_add_tree_top: random and directed dot-product checks on a sign-switching instance and two tied-sign instances.
module tb_npu_add_tree_top;
`ifdef NPU_ADD_TREE_PIPE_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif
  logic        clk = 0;
  logic        rst = 1;
  logic [63:0] add_tree_data = '0;
  logic [63:0] add_tree_para = '0;
  logic        is_signed_data = 0;
  logic [18:0] res_m, res_s, res_u;
  logic [18:0] q_m[$], q_s[$], q_u[$];
  int n_chk = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  npu_add_tree_top u_m (.clk(clk), .rst(rst), .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
                        .is_signed_data(is_signed_data), .add_result(res_m));
  npu_add_tree_top u_s (.clk(clk), .rst(rst), .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
                        .is_signed_data(1'b1), .add_result(res_s));
  npu_add_tree_top u_u (.clk(clk), .rst(rst), .add_tree_data(add_tree_data), .add_tree_para(add_tree_para),
                        .is_signed_data(1'b0), .add_result(res_u));
  function automatic logic [18:0] ref_dot(input logic [63:0] d, input logic [63:0] w, input logic s);
    int acc = 0;
    for (int i = 0; i < 8; i++) begin
      int dv = s ? int'($signed(d[8*i +: 8])) : int'(d[8*i +: 8]);
      acc += dv * int'($signed(w[8*i +: 8]));
    end
    return 19'(acc);
  endfunction
  task automatic check(input string tag, input logic [18:0] got, input logic [18:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%05h) expected %0d (0x%05h)", tag, $signed(got), got, $signed(exp), exp);
    end
  endtask
  task automatic step(input string tag, input logic r, input logic [63:0] d, input logic [63:0] w, input logic s);
    rst = r;
    add_tree_data = d;
    add_tree_para = w;
    is_signed_data = s;
    if (r) begin
      foreach (q_m[i]) q_m[i] = '0;
      foreach (q_s[i]) q_s[i] = '0;
      foreach (q_u[i]) q_u[i] = '0;
    end
    q_m.push_back(r ? 19'd0 : ref_dot(d, w, s));
    q_s.push_back(r ? 19'd0 : ref_dot(d, w, 1'b1));
    q_u.push_back(r ? 19'd0 : ref_dot(d, w, 1'b0));
    @(posedge clk);
    #1;
    if (q_m.size() == LAT) begin
      check({tag, "/m"}, res_m, q_m.pop_front());
      check({tag, "/s"}, res_s, q_s.pop_front());
      check({tag, "/u"}, res_u, q_u.pop_front());
    end
  endtask
  task automatic direct(input string tag, input logic [63:0] d, input logic [63:0] w, input logic s, input int exp);
    for (int k = 0; k < LAT; k++) step(tag, 1'b0, d, w, s);
    check({tag, "/const"}, res_m, 19'(exp));
  endtask
  initial begin
    logic [63:0] d, w;
    logic [18:0] e;
    for (int k = 0; k < 3; k++) step("reset", 1'b1, 64'h0, 64'h0, 1'b0);
    check("reset_zero", res_m, 19'd0);
    direct("all_ff_80_u", {8{8'hFF}}, {8{8'h80}}, 1'b0, -261120);
    check("all_ff_80_u_hex", res_m, 19'h40400);
    direct("all_ff_7f_u", {8{8'hFF}}, {8{8'h7F}}, 1'b0, 259080);
    direct("all_ff_7f_s", {8{8'hFF}}, {8{8'h7F}}, 1'b1, -1016);
    direct("all_80_80_s", {8{8'h80}}, {8{8'h80}}, 1'b1, 131072);
    direct("all_80_80_u", {8{8'h80}}, {8{8'h80}}, 1'b0, -131072);
    direct("lane5", 64'h0000_0300_0000_0000, 64'h0000_FE00_0000_0000, 1'b1, -6);
    direct("lane0", 64'h0000_0000_0000_0005, 64'h0000_0000_0000_0007, 1'b0, 35);
    for (int k = 0; k < 4; k++) begin
      d = {$urandom, $urandom};
      w = {$urandom, $urandom};
      e = ref_dot(d, w, 1'b1);
      direct("lane_rot", {d[55:0], d[63:56]}, {w[55:0], w[63:56]}, 1'b1, int'($signed(e)));
    end
    for (int k = 0; k < 4; k++) step("rst_hold", 1'b1, {8{8'hFF}}, {8{8'h7F}}, 1'b0);
    check("rst_hold_zero", res_m, 19'd0);
    step("rst_release", 1'b0, {8{8'hFF}}, {8{8'h7F}}, 1'b0);
    if (LAT == 2) check("rst_release_pipe_zero", res_m, 19'd0);
    step("rst_release2", 1'b0, {8{8'h01}}, {8{8'h02}}, 1'b1);
    for (int k = 0; k < 10000; k++)
      step("random", k == 5000, {$urandom, $urandom}, {$urandom, $urandom}, 1'($urandom));
    for (int k = 0; k < LAT; k++) step("drain", 1'b0, 64'h0, 64'h0, 1'b0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end
endmodule
